// File: rtl/rom_stream_reader_pkg.sv
// Shared types and constants for rom_stream_reader: FSM state encoding and
// the 4-byte "ASRM" image header magic.
package rom_stream_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    STREAM,
    DONE,
    ERR
  } state_t;

  localparam int HDR_LEN = 4;

  localparam logic [7:0] MAGIC_0 = 8'h41;
  localparam logic [7:0] MAGIC_1 = 8'h53;
  localparam logic [7:0] MAGIC_2 = 8'h52;
  localparam logic [7:0] MAGIC_3 = 8'h4D;

  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = MAGIC_0;
      2'd1:    b = MAGIC_1;
      2'd2:    b = MAGIC_2;
      default: b = MAGIC_3;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rom_stream_reader.sv
// Reads an "ASRM"-headed image from a one-cycle registered ROM and streams the
// payload over valid/ready. Define ROM_STREAM_CHECKSUM_EN for the running checksum.
module rom_stream_reader
  import rom_stream_reader_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int IMAGE_LEN = 46
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_enable_out,
  input  logic [7:0]        rom_data,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        checksum
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMAGE_LEN - 1);
  localparam logic [ADDR_W-1:0] HDR_LAST  = ADDR_W'(HDR_LEN - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] p, p_next;
  logic              dv, dv_next;
  logic              adv, fire, active;
  logic              clear_flags, set_done, set_error;

  // p tracks the address the ROM will present next cycle; dv says the ROM
  // output already holds byte p, so a stall simply re-reads the same address.
  always_comb begin
    state_next  = state;
    dv_next     = dv;
    adv         = 1'b0;
    fire        = 1'b0;
    active      = 1'b0;
    out_valid   = 1'b0;
    clear_flags = 1'b0;
    set_done    = 1'b0;
    set_error   = 1'b0;
    case (state)
      HDR: begin
        active = 1'b1;
        if (!dv) begin
          dv_next = 1'b1;
        end else begin
          adv = 1'b1;
          if (rom_data != magic_byte(p[1:0])) begin
            state_next = ERR;
            dv_next    = 1'b0;
            set_error  = 1'b1;
          end else if (p == HDR_LAST) begin
            state_next = STREAM;
          end
        end
      end
      STREAM: begin
        active    = 1'b1;
        out_valid = dv;
        fire      = dv & out_ready;
        adv       = fire;
        if (fire && (p == LAST_ADDR)) begin
          state_next = DONE;
          dv_next    = 1'b0;
          set_done   = 1'b1;
        end
      end
      default: begin
        if (start) begin
          state_next  = HDR;
          dv_next     = 1'b0;
          clear_flags = 1'b1;
        end
      end
    endcase
  end

  assign rom_addr       = active ? (p + ADDR_W'(adv)) : '0;
  assign p_next         = (set_done || set_error) ? '0 : rom_addr;
  assign rom_enable_out = active;
  assign busy           = active;
  assign out_data       = out_valid ? rom_data : 8'h00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      p     <= '0;
      dv    <= 1'b0;
    end else begin
      state <= state_next;
      p     <= p_next;
      dv    <= dv_next;
    end
  end

  // done/error are sticky until the next accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done  <= 1'b0;
      error <= 1'b0;
    end else if (clear_flags) begin
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      if (set_done) done <= 1'b1;
      if (set_error) error <= 1'b1;
    end
  end

`ifdef ROM_STREAM_CHECKSUM_EN
  logic [7:0] sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum <= 8'h00;
    end else if (clear_flags) begin
      sum <= 8'h00;
    end else if (fire) begin
      sum <= sum + out_data;
    end
  end

  assign checksum = sum;
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench for rom_stream_reader: a 6-byte and a 46-byte instance,
// each with its own registered ROM model.
module tb_rom_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       s_start, s_ready, s_en, s_valid, s_busy, s_done, s_error;
  logic [5:0] s_addr;
  logic [7:0] s_rom_data = 8'h00;
  logic [7:0] s_data, s_sum;

  logic       f_start, f_ready, f_en, f_valid, f_busy, f_done, f_error;
  logic [5:0] f_addr;
  logic [7:0] f_rom_data = 8'h00;
  logic [7:0] f_data, f_sum;

  logic [7:0] s_mem [64];
  logic [7:0] f_mem [64];

  logic [7:0] q_s [$];
  logic [7:0] q_f [$];
  int s_pops = 0;
  int f_pops = 0;
  int n_assert = 0;
  int n_fail = 0;
  logic [7:0] model_sum;

  rom_stream_reader #(.ADDR_W(6), .IMAGE_LEN(6)) u_small (
    .clk(clk), .reset(reset), .start(s_start),
    .rom_addr(s_addr), .rom_enable_out(s_en), .rom_data(s_rom_data),
    .out_data(s_data), .out_valid(s_valid), .out_ready(s_ready),
    .busy(s_busy), .done(s_done), .error(s_error), .checksum(s_sum)
  );

  rom_stream_reader #(.ADDR_W(6), .IMAGE_LEN(46)) u_full (
    .clk(clk), .reset(reset), .start(f_start),
    .rom_addr(f_addr), .rom_enable_out(f_en), .rom_data(f_rom_data),
    .out_data(f_data), .out_valid(f_valid), .out_ready(f_ready),
    .busy(f_busy), .done(f_done), .error(f_error), .checksum(f_sum)
  );

  always @(posedge clk) begin
    s_rom_data <= s_en ? s_mem[s_addr] : 8'h00;
    f_rom_data <= f_en ? f_mem[f_addr] : 8'h00;
  end

  function automatic logic [7:0] full_payload(input int a);
    return 8'((56 * a + 54) % 256);
  endfunction

  function automatic logic [7:0] exp_sum(input logic [7:0] m);
`ifdef ROM_STREAM_CHECKSUM_EN
    return m;
`else
    return m & 8'h00;
`endif
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge on the chosen instance, setting its ready first.
  task automatic apply_stimulus(input bit full, input logic rdy);
    @(posedge clk); #1;
    if (full) begin f_ready = rdy; f_start = 1'b1; end
    else      begin s_ready = rdy; s_start = 1'b1; end
    @(posedge clk); #1;
    s_start = 1'b0;
    f_start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && s_valid && s_ready) begin
      check_output("s_sb_nonempty", 32'(q_s.size() != 0), 32'd1);
      if (q_s.size() != 0) begin
        check_output("s_sb_byte", 32'(s_data), 32'(q_s.pop_front()));
        s_pops++;
      end
    end
    if (!reset && f_valid && f_ready) begin
      check_output("f_sb_nonempty", 32'(q_f.size() != 0), 32'd1);
      if (q_f.size() != 0) begin
        check_output("f_sb_byte", 32'(f_data), 32'(q_f.pop_front()));
        f_pops++;
      end
    end
  end

  initial begin
    reset = 1'b1; s_start = 1'b0; f_start = 1'b0; s_ready = 1'b0; f_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin s_mem[i] = 8'h00; f_mem[i] = 8'h00; end
    s_mem[0] = 8'h41; s_mem[1] = 8'h53; s_mem[2] = 8'h52; s_mem[3] = 8'h4D;
    s_mem[4] = 8'h10; s_mem[5] = 8'h20;
    f_mem[0] = 8'h41; f_mem[1] = 8'h53; f_mem[2] = 8'h52; f_mem[3] = 8'h4D;
    for (int a = 4; a < 46; a++) f_mem[a] = full_payload(a);

    $display("[TB] reset state");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_addr", 32'(s_addr), 32'd0);
    check_output("rst_en", 32'(s_en), 32'd0);
    check_output("rst_valid", 32'(s_valid), 32'd0);
    check_output("rst_busy", 32'(s_busy), 32'd0);
    check_output("rst_done", 32'(s_done), 32'd0);
    check_output("rst_error", 32'(s_error), 32'd0);
    check_output("rst_sum", 32'(s_sum), 32'd0);
    check_output("rst_f_valid", 32'(f_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("[TB] small image, ready held high");
    q_s.push_back(8'h10); q_s.push_back(8'h20);
    apply_stimulus(1'b0, 1'b1);
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      check_output("t1_valid", 32'(s_valid), 32'(c == 5 || c == 6));
      check_output("t1_busy", 32'(s_busy), 32'(c <= 6));
      check_output("t1_done", 32'(s_done), 32'(c >= 7));
      @(posedge clk); #1;
    end
    check_output("t1_sum", 32'(s_sum), 32'(exp_sum(8'h30)));
    check_output("t1_error", 32'(s_error), 32'd0);
    check_output("t1_pops", 32'(s_pops), 32'd2);

    $display("[TB] small image, stalled at first valid");
    q_s.push_back(8'h10); q_s.push_back(8'h20);
    apply_stimulus(1'b0, 1'b0);
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      if (c < 5) check_output("t2_early_valid", 32'(s_valid), 32'd0);
      if (c >= 5 && c <= 7) begin
        check_output("t2_stall_valid", 32'(s_valid), 32'd1);
        check_output("t2_stall_data", 32'(s_data), 32'h10);
        check_output("t2_stall_addr", 32'(s_addr), 32'd4);
      end
      @(posedge clk); #1;
      s_ready = (c >= 7);
    end
    check_output("t2_done", 32'(s_done), 32'd1);
    check_output("t2_pops", 32'(s_pops), 32'd4);
    check_output("t2_sum", 32'(s_sum), 32'(exp_sum(8'h30)));

    $display("[TB] bad header, then recovery");
    @(posedge clk); #1;
    s_mem[2] = 8'h58;
    apply_stimulus(1'b0, 1'b1);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      check_output("t3_valid", 32'(s_valid), 32'd0);
      check_output("t3_error", 32'(s_error), 32'(c >= 4));
      check_output("t3_busy", 32'(s_busy), 32'(c <= 3));
      check_output("t3_done", 32'(s_done), 32'd0);
      @(posedge clk); #1;
    end
    s_mem[2] = 8'h52;
    q_s.push_back(8'h10); q_s.push_back(8'h20);
    apply_stimulus(1'b0, 1'b1);
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      if (c == 0) check_output("t3_err_cleared", 32'(s_error), 32'd0);
      @(posedge clk); #1;
    end
    check_output("t3_retry_done", 32'(s_done), 32'd1);
    check_output("t3_pops", 32'(s_pops), 32'd6);

    $display("[TB] start pulses while busy");
    q_s.push_back(8'h10); q_s.push_back(8'h20);
    apply_stimulus(1'b0, 1'b1);
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      check_output("t6_valid", 32'(s_valid), 32'(c == 5 || c == 6));
      check_output("t6_done", 32'(s_done), 32'(c >= 7));
      @(posedge clk); #1;
      s_start = (c == 1 || c == 4);
    end
    check_output("t6_pops", 32'(s_pops), 32'd8);
    check_output("t6_sum", 32'(s_sum), 32'(exp_sum(8'h30)));

    $display("[TB] full image, random ready");
    model_sum = 8'h00;
    for (int a = 4; a < 46; a++) begin
      q_f.push_back(full_payload(a));
      model_sum = model_sum + full_payload(a);
    end
    apply_stimulus(1'b1, 1'b0);
    for (int cyc = 0; cyc < 2000 && !f_done; cyc++) begin
      @(negedge clk);
      @(posedge clk); #1;
      f_ready = 1'($urandom_range(0, 1));
    end
    check_output("t4_done_in_time", 32'(f_done), 32'd1);
    check_output("t4_pops", 32'(f_pops), 32'd42);
    check_output("t4_queue_empty", 32'(q_f.size()), 32'd0);
    check_output("t4_sum", 32'(f_sum), 32'(exp_sum(model_sum)));

    $display("[TB] reset during stream");
    for (int a = 4; a <= 10; a++) q_f.push_back(full_payload(a));
    apply_stimulus(1'b1, 1'b1);
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_output("t5_p10_data", 32'(f_data), 32'(full_payload(10)));
    #2;
    reset = 1'b1;
    #1;
    check_output("t5_rst_valid", 32'(f_valid), 32'd0);
    check_output("t5_rst_busy", 32'(f_busy), 32'd0);
    check_output("t5_rst_addr", 32'(f_addr), 32'd0);
    check_output("t5_rst_en", 32'(f_en), 32'd0);
    check_output("t5_rst_data", 32'(f_data), 32'd0);
    check_output("t5_rst_sum", 32'(f_sum), 32'd0);
    check_output("t5_queue_empty", 32'(q_f.size()), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int a = 4; a < 46; a++) q_f.push_back(full_payload(a));
    apply_stimulus(1'b1, 1'b1);
    for (int cyc = 0; cyc < 200 && !f_done; cyc++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    check_output("t5_replay_done", 32'(f_done), 32'd1);
    check_output("t5_replay_pops", 32'(f_pops), 32'd91);
    check_output("t5_replay_sum", 32'(f_sum), 32'(exp_sum(model_sum)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
